// File: rtl/demux_sched.sv
// -----------------------------------------------------------------------------
// demux_sched
//
// Upstream driver for a 1-to-4 demux (inputs y, sel[1:0] -> outputs a,b,c,d).
// Accepts 1-bit symbols over a valid/ready handshake. Each symbol goes to an
// addressed channel (in_dest) or to the next round-robin channel (mode_rr=1).
// sel/y are then held stable for HOLD_CYCLES cycles. One return-to-zero cycle
// (y=0) follows so all demux outputs fall to 0 between symbols.
//
// Parameters
//   HOLD_CYCLES  cycles sel/y are driven per symbol (1..15)
//   CNT_W        width of each per-channel delivery counter
//
// Ports
//   clk         in   1          rising-edge clock
//   rst         in   1          asynchronous, active-high reset
//   in_valid    in   1          symbol offered
//   in_data     in   1          symbol value, forwarded to y
//   in_dest     in   2          destination channel when mode_rr=0
//   mode_rr     in   1          1: round-robin destination, in_dest ignored
//   in_ready    out  1          symbol can be accepted this cycle
//   sel         out  2          demux select (registered)
//   y           out  1          demux data input (registered)
//   out_strobe  out  1          sel/y settled; downstream samples a..d now
//   busy        out  1          high whenever a symbol is in flight
//   ch_count    out  4*CNT_W    per-channel saturating delivery counts,
//                               channel k at [k*CNT_W +: CNT_W]
//                               (only with DEMUX_SCHED_CNT_EN defined)
//
// Build option
//   DEMUX_SCHED_CNT_EN  adds the ch_count port and its counters.
// -----------------------------------------------------------------------------
module demux_sched #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_data,
    input  logic [1:0] in_dest,
    input  logic       mode_rr,
    output logic       in_ready,
    output logic [1:0] sel,
    output logic       y,
    output logic       out_strobe,
    output logic       busy
`ifdef DEMUX_SCHED_CNT_EN
    ,
    output logic [4*CNT_W-1:0] ch_count
`endif
);

    // Elaboration-time parameter checks.
    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
            $error("demux_sched: HOLD_CYCLES=%0d outside 1..15", HOLD_CYCLES);
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("demux_sched: CNT_W=%0d must be at least 1", CNT_W);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] hold_cnt;
    logic [1:0] rr_ptr;
    logic       accept;
    logic [1:0] dest;

    // in_ready is gated by rst so nothing looks acceptable while reset is held.
    assign in_ready   = (state == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign dest       = mode_rr ? rr_ptr : in_dest;
    assign busy       = (state != IDLE);
    // Decoded from registered state, so it drops to 0 the moment reset hits.
    assign out_strobe = (state == DRIVE) && (hold_cnt == 4'd0);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others; blocking here would create ordering
    // races between always blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment before the case keeps state_next driven on
    // every path, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = DRIVE;
            DRIVE:   if (hold_cnt == 4'd0) state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: sel/y capture, hold counter and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= 2'd0;
            y        <= 1'b0;
            hold_cnt <= 4'd0;
            rr_ptr   <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sel      <= dest;
                        y        <= in_data;
                        hold_cnt <= 4'(HOLD_CYCLES - 1);
                        // Only round-robin accepts consume a pointer slot.
                        if (mode_rr) rr_ptr <= rr_ptr + 2'd1;
                    end
                end
                DRIVE: begin
                    if (hold_cnt == 4'd0) begin
                        // Entering GAP: return-to-zero, sel left as is.
                        y <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DEMUX_SCHED_CNT_EN
    // Per-channel delivery counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_count <= '0;
        end else if (out_strobe) begin
            for (int k = 0; k < 4; k++) begin
                if (sel == 2'(k) && ch_count[k*CNT_W +: CNT_W] != {CNT_W{1'b1}}) begin
                    ch_count[k*CNT_W +: CNT_W] <= ch_count[k*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_sched.sv
// -----------------------------------------------------------------------------
// tb_demux_sched
//
// Directed bench for demux_sched. Main instance uses HOLD_CYCLES=2; a second
// instance with HOLD_CYCLES=1 covers the single-cycle hold boundary. A
// behavioural 1-to-4 demux sits downstream of the main instance.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux_sched;

`ifdef DEMUX_SCHED_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_data, mode_rr;
    logic [1:0] in_dest;
    logic       in_ready, y, out_strobe, busy;
    logic [1:0] sel;

    logic       h1_valid, h1_data, h1_mode_rr;
    logic [1:0] h1_dest;
    logic       h1_ready, h1_y, h1_strobe, h1_busy;
    logic [1:0] h1_sel;

`ifdef DEMUX_SCHED_CNT_EN
    logic [4*CNT_W-1:0] ch_count;
    logic [4*CNT_W-1:0] h1_ch_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    demux_sched #(.HOLD_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .mode_rr    (mode_rr),
        .in_ready   (in_ready),
        .sel        (sel),
        .y          (y),
        .out_strobe (out_strobe),
        .busy       (busy)
`ifdef DEMUX_SCHED_CNT_EN
        ,
        .ch_count   (ch_count)
`endif
    );

    demux_sched #(.HOLD_CYCLES(1), .CNT_W(CNT_W)) dut_h1 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (h1_valid),
        .in_data    (h1_data),
        .in_dest    (h1_dest),
        .mode_rr    (h1_mode_rr),
        .in_ready   (h1_ready),
        .sel        (h1_sel),
        .y          (h1_y),
        .out_strobe (h1_strobe),
        .busy       (h1_busy)
`ifdef DEMUX_SCHED_CNT_EN
        ,
        .ch_count   (h1_ch_count)
`endif
    );

    // Downstream 1-to-4 demux, packed as {d,c,b,a}.
    logic [3:0] demux_out;
    always_comb begin
        demux_out      = 4'b0000;
        demux_out[sel] = y;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Offer one symbol in IDLE and run it to the next IDLE, checking every cycle.
    // Inputs are scrambled while busy to show they are ignored.
    task automatic send_addr(input logic [1:0] d, input logic v, input string tag);
        in_valid = 1'b1; in_dest = d; in_data = v; mode_rr = 1'b0;
        check({tag, " ready"}, in_ready, 1);
        step();                                   // DRIVE, cycle 1
        in_valid = 1'b1; in_dest = ~d; in_data = ~v;
        check({tag, " sel1"}, sel, d);
        check({tag, " y1"}, y, v);
        check({tag, " stb1"}, out_strobe, 0);
        step();                                   // DRIVE, cycle 2
        in_valid = 1'b0;
        check({tag, " stb2"}, out_strobe, 1);
        check({tag, " abcd"}, demux_out, 4'(v) << d);
        step();                                   // GAP
        check({tag, " gap abcd"}, demux_out, 0);
        check({tag, " gap sel"}, sel, d);
        check({tag, " gap stb"}, out_strobe, 0);
        step();                                   // back to IDLE
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = 1'b0; in_dest = 2'd0; mode_rr = 1'b0;
        h1_valid = 1'b0; h1_data = 1'b0; h1_dest = 2'd0; h1_mode_rr = 1'b0;
        step();
        check("rst ready", in_ready, 0);
        check("rst busy", busy, 0);
        rst = 1'b0;
        step();
        check("rel ready", in_ready, 1);

        // 1: asynchronous reset mid-DRIVE, no clock edge needed.
        in_valid = 1'b1; in_dest = 2'd3; in_data = 1'b1;
        step();
        in_valid = 1'b0;
        check("t1 pre sel", sel, 3);
        check("t1 pre busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t1 async sel", sel, 0);
        check("t1 async y", y, 0);
        check("t1 async busy", busy, 0);
        check("t1 async stb", out_strobe, 0);
        check("t1 async ready", in_ready, 0);
        step();
        rst = 1'b0;
        #1 check("t1 rel ready", in_ready, 1);
        step();

        // 2: addressed symbol to channel 2, data 1.
        send_addr(2'd2, 1'b1, "t2");
        check("t2 idle ready", in_ready, 1);
        check("t2 idle busy", busy, 0);

        // 3: round-robin, in_valid held high, 5 symbols spaced 4 cycles.
        in_valid = 1'b1; in_data = 1'b1; mode_rr = 1'b1; in_dest = 2'd3;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3 ready%0d", k), in_ready, 1);
            step();
            if (k == 4) in_valid = 1'b0;
            check($sformatf("t3 sel%0d", k), sel, k % 4);
            check($sformatf("t3 nready%0d", k), in_ready, 0);
            step();
            check($sformatf("t3 stb%0d", k), out_strobe, 1);
            step();
            check($sformatf("t3 gapy%0d", k), y, 0);
            step();
        end
        step();
        check("t3 no extra", busy, 0);

        // 4: sweep all destinations and data values.
        for (int d = 0; d < 4; d++) begin
            for (int v = 0; v < 2; v++) begin
                send_addr(2'(d), 1'(v), $sformatf("t4 d%0d v%0d", d, v));
            end
        end

        // 5: reset during DRIVE of a round-robin symbol; rr_ptr is 1 here.
        in_valid = 1'b1; mode_rr = 1'b1; in_data = 1'b1;
        step();
        in_valid = 1'b0;
        check("t5 sel", sel, 1);
        #2 rst = 1'b1;
        #1 check("t5 stb", out_strobe, 0);
        step();
        check("t5 stb held", out_strobe, 0);
        rst = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("t5 rr sel", sel, 0);
        step();
        check("t5 rr stb", out_strobe, 1);
        step();
        step();

        // HOLD_CYCLES=1: strobe in the first and only DRIVE cycle.
        h1_valid = 1'b1; h1_dest = 2'd1; h1_data = 1'b1;
        check("h1 ready", h1_ready, 1);
        step();
        h1_valid = 1'b0;
        check("h1 sel", h1_sel, 1);
        check("h1 y", h1_y, 1);
        check("h1 stb", h1_strobe, 1);
        step();
        check("h1 gap y", h1_y, 0);
        check("h1 gap stb", h1_strobe, 0);
        check("h1 gap busy", h1_busy, 1);
        step();
        check("h1 idle", h1_ready, 1);

`ifdef DEMUX_SCHED_CNT_EN
        // 6: five symbols to channel 1 saturate a 2-bit counter at 3.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6 clear", ch_count, 0);
        step();
        for (int k = 0; k < 5; k++) send_addr(2'd1, 1'b1, $sformatf("t6 s%0d", k));
        check("t6 count", ch_count, 8'b00_00_11_00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
